// File: rtl/alu_issue_unit.sv
// alu_issue_unit: EX-stage issue/collect wrapper around a clocked 32-bit ALU.
// Accepts one decoded MIPS instruction per in_valid/in_ready handshake. It decodes
// opcode/funct into ALU control, operands and shift amount, waits out the ALU latency
// and captures the result. It then flags signed overflow on trapping ops and holds
// result, destination and status on the out_* side until out_ready.
// Ports:
//   clk, rst_n (async, active low), flush (sync abort)
//   in_valid/in_ready + instruction fields in_opcode/in_funct/in_shamt/in_rt/in_rd,
//     operand values in_rs_data/in_rt_data, immediate in_imm
//   alu_data1/alu_data2/alu_control/alu_shamt -> ALU, alu_result <- ALU
//   out_valid/out_ready + out_result/out_dest/out_wr_en/out_overflow/out_illegal
// Only one operation is in flight at a time.
module alu_issue_unit #(
  parameter int unsigned ALU_LAT = 1,
  parameter bit          TRAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_shamt,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  input  logic [15:0] in_imm,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  output logic [3:0]  alu_control,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_dest,
  output logic        out_wr_en,
  output logic        out_overflow,
  output logic        out_illegal
);

  localparam int unsigned CntW = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

  localparam logic [3:0] CtrlAdd  = 4'b0000;
  localparam logic [3:0] CtrlSub  = 4'b0001;
  localparam logic [3:0] CtrlAnd  = 4'b0010;
  localparam logic [3:0] CtrlOr   = 4'b0011;
  localparam logic [3:0] CtrlSll  = 4'b0100;
  localparam logic [3:0] CtrlSrl  = 4'b0101;
  localparam logic [3:0] CtrlSra  = 4'b0110;
  localparam logic [3:0] CtrlLess = 4'b1000;
  localparam logic [3:0] CtrlNor  = 4'b1001;

  typedef enum logic [1:0] {StIdle, StExec, StWait, StDone} state_e;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           ready_q, ready_d;
  logic [31:0]    alu_data1_q, alu_data1_d;
  logic [31:0]    alu_data2_q, alu_data2_d;
  logic [3:0]     alu_control_q, alu_control_d;
  logic [4:0]     alu_shamt_q, alu_shamt_d;
  logic           trap_q, trap_d;
  logic           sub_q, sub_d;
  logic [31:0]    out_result_q, out_result_d;
  logic [4:0]     out_dest_q, out_dest_d;
  logic           out_wr_en_q, out_wr_en_d;
  logic           out_overflow_q, out_overflow_d;
  logic           out_illegal_q, out_illegal_d;

  // Decoded view of the instruction currently on the in_* port.
  logic        dec_legal;
  logic [3:0]  dec_ctrl;
  logic [31:0] dec_d1, dec_d2;
  logic [4:0]  dec_shamt, dec_dest;
  logic        dec_trap, dec_sub;
  logic [31:0] imm_sext, imm_zext;

  assign imm_sext = {{16{in_imm[15]}}, in_imm};
  assign imm_zext = {16'h0000, in_imm};

  always_comb begin
    dec_legal = 1'b1;
    dec_ctrl  = CtrlAdd;
    dec_d1    = in_rs_data;
    dec_d2    = in_rt_data;
    dec_shamt = 5'd0;
    dec_dest  = in_rd;
    dec_trap  = 1'b0;
    dec_sub   = 1'b0;
    if (in_opcode == 6'b000000) begin
      case (in_funct)
        6'b100000: begin dec_ctrl = CtrlAdd; dec_trap = 1'b1; end
        6'b100001: dec_ctrl = CtrlAdd;
        6'b100010: begin dec_ctrl = CtrlSub; dec_trap = 1'b1; dec_sub = 1'b1; end
        6'b100011: begin dec_ctrl = CtrlSub; dec_sub = 1'b1; end
        6'b100100: dec_ctrl = CtrlAnd;
        6'b100101: dec_ctrl = CtrlOr;
        6'b100111: dec_ctrl = CtrlNor;
        6'b101010: dec_ctrl = CtrlLess;
        6'b000000, 6'b000010, 6'b000011: begin
          // Shifts operate on rt; rs is not a source.
          dec_ctrl  = (in_funct == 6'b000000) ? CtrlSll :
                      (in_funct == 6'b000010) ? CtrlSrl : CtrlSra;
          dec_d1    = in_rt_data;
          dec_d2    = 32'h0;
          dec_shamt = in_shamt;
        end
        default: dec_legal = 1'b0;
      endcase
    end else begin
      dec_dest = in_rt;
      case (in_opcode)
        6'b001000: begin dec_ctrl = CtrlAdd;  dec_d2 = imm_sext; dec_trap = 1'b1; end
        6'b001001: begin dec_ctrl = CtrlAdd;  dec_d2 = imm_sext; end
        6'b001010: begin dec_ctrl = CtrlLess; dec_d2 = imm_sext; end
        6'b001100: begin dec_ctrl = CtrlAnd;  dec_d2 = imm_zext; end
        6'b001101: begin dec_ctrl = CtrlOr;   dec_d2 = imm_zext; end
        default:   dec_legal = 1'b0;
      endcase
    end
  end

  // Signed overflow of the captured result against the operands the ALU actually saw.
  logic ovf_raw;
  always_comb begin
    if (sub_q) begin
      ovf_raw = (alu_data1_q[31] != alu_data2_q[31]) && (alu_result[31] != alu_data1_q[31]);
    end else begin
      ovf_raw = (alu_data1_q[31] == alu_data2_q[31]) && (alu_result[31] != alu_data1_q[31]);
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    alu_data1_d    = alu_data1_q;
    alu_data2_d    = alu_data2_q;
    alu_control_d  = alu_control_q;
    alu_shamt_d    = alu_shamt_q;
    trap_d         = trap_q;
    sub_d          = sub_q;
    out_result_d   = out_result_q;
    out_dest_d     = out_dest_q;
    out_wr_en_d    = out_wr_en_q;
    out_overflow_d = out_overflow_q;
    out_illegal_d  = out_illegal_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid && ready_q && !flush) begin
          out_result_d   = 32'h0;
          out_dest_d     = dec_dest;
          out_wr_en_d    = 1'b0;
          out_overflow_d = 1'b0;
          out_illegal_d  = !dec_legal;
          if (dec_legal) begin
            alu_data1_d   = dec_d1;
            alu_data2_d   = dec_d2;
            alu_control_d = dec_ctrl;
            alu_shamt_d   = dec_shamt;
            trap_d        = dec_trap;
            sub_d         = dec_sub;
            cnt_d         = CntW'(ALU_LAT);
            state_d       = StExec;
          end else begin
            state_d = StDone;
          end
        end
      end
      StExec: begin
        // The first EXEC cycle is the ALU's operand sample edge, so EXEC spans
        // ALU_LAT+1 cycles before the result is guaranteed valid in WAIT.
        if (cnt_q == '0) begin
          state_d = StWait;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWait: begin
        out_result_d   = alu_result;
        out_overflow_d = TRAP_EN && trap_q && ovf_raw;
        out_wr_en_d    = (out_dest_q != 5'd0) && !(TRAP_EN && trap_q && ovf_raw);
        state_d        = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d        = StIdle;
      cnt_d          = '0;
      out_result_d   = 32'h0;
      out_dest_d     = 5'd0;
      out_wr_en_d    = 1'b0;
      out_overflow_d = 1'b0;
      out_illegal_d  = 1'b0;
    end
  end

  // in_ready is registered so it reads 0 during reset and rises on the first edge after release.
  assign ready_d = (state_d == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      ready_q        <= 1'b0;
      alu_data1_q    <= 32'h0;
      alu_data2_q    <= 32'h0;
      alu_control_q  <= 4'h0;
      alu_shamt_q    <= 5'd0;
      trap_q         <= 1'b0;
      sub_q          <= 1'b0;
      out_result_q   <= 32'h0;
      out_dest_q     <= 5'd0;
      out_wr_en_q    <= 1'b0;
      out_overflow_q <= 1'b0;
      out_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ready_q        <= ready_d;
      alu_data1_q    <= alu_data1_d;
      alu_data2_q    <= alu_data2_d;
      alu_control_q  <= alu_control_d;
      alu_shamt_q    <= alu_shamt_d;
      trap_q         <= trap_d;
      sub_q          <= sub_d;
      out_result_q   <= out_result_d;
      out_dest_q     <= out_dest_d;
      out_wr_en_q    <= out_wr_en_d;
      out_overflow_q <= out_overflow_d;
      out_illegal_q  <= out_illegal_d;
    end
  end

  assign in_ready     = ready_q;
  assign alu_data1    = alu_data1_q;
  assign alu_data2    = alu_data2_q;
  assign alu_control  = alu_control_q;
  assign alu_shamt    = alu_shamt_q;
  assign out_valid    = (state_q == StDone);
  assign out_result   = out_result_q;
  assign out_dest     = out_dest_q;
  assign out_wr_en    = out_wr_en_q;
  assign out_overflow = out_overflow_q;
  assign out_illegal  = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed, table-driven bench for alu_issue_unit with a behavioural clocked ALU.
module tb_alu_issue_unit;

  localparam int unsigned ALU_LAT = 1;
  localparam int NVEC = 21;

  logic        clk, rst_n, flush;
  logic        in_valid, in_ready;
  logic [5:0]  in_opcode, in_funct;
  logic [4:0]  in_shamt, in_rt, in_rd;
  logic [31:0] in_rs_data, in_rt_data;
  logic [15:0] in_imm;
  logic [31:0] alu_data1, alu_data2, alu_result;
  logic [3:0]  alu_control;
  logic [4:0]  alu_shamt;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic        out_wr_en, out_overflow, out_illegal;

  alu_issue_unit #(.ALU_LAT(ALU_LAT), .TRAP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_shamt(in_shamt),
    .in_rt(in_rt), .in_rd(in_rd), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_control(alu_control),
    .alu_shamt(alu_shamt), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dest(out_dest), .out_wr_en(out_wr_en), .out_overflow(out_overflow),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU32Bit: samples operands on posedge, result ALU_LAT stages later.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c, input logic [4:0] s);
    case (c)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b1001: return ~(a | b);
      4'b1000: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0100: return a << s;
      4'b0101: return a >> s;
      4'b0110: return $unsigned($signed(a) >>> s);
      default: return 32'h0;
    endcase
  endfunction

  logic [31:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_f(alu_data1, alu_data2, alu_control, alu_shamt);
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_result = alu_pipe[ALU_LAT-1];

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [15:0] imm;
    logic        ill;
    logic [31:0] res;
    logic [4:0]  dst;
    logic        wr;
    logic        ovf;
    logic [3:0]  ctl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  ash;
  } vec_t;

  vec_t vecs [NVEC];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_opcode  = v.op;
    in_funct   = v.fn;
    in_shamt   = v.sh;
    in_rt      = v.rt;
    in_rd      = v.rd;
    in_rs_data = v.rsd;
    in_rt_data = v.rtd;
    in_imm     = v.imm;
  endtask

  // Present v for one edge; returns #1 after that accept edge.
  task automatic accept(input vec_t v);
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid; returns number of edges waited (capped).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    bit seen;
    //            op       fn       sh    rt     rd     rs_data       rt_data       imm       ill  res           dst    wr   ovf  ctl      d1            d2            ash
    vecs[0]  = '{6'h00, 6'b100001, 5'd0, 5'd1, 5'd3, 32'd5,        32'd7,        16'h0,    1'b0, 32'd12,       5'd3,  1'b1, 1'b0, 4'b0000, 32'd5,        32'd7,        5'd0};
    vecs[1]  = '{6'h00, 6'b100000, 5'd0, 5'd1, 5'd4, 32'h7FFFFFFF, 32'd1,        16'h0,    1'b0, 32'h80000000, 5'd4,  1'b0, 1'b1, 4'b0000, 32'h7FFFFFFF, 32'd1,        5'd0};
    vecs[2]  = '{6'h00, 6'b100001, 5'd0, 5'd1, 5'd4, 32'h7FFFFFFF, 32'd1,        16'h0,    1'b0, 32'h80000000, 5'd4,  1'b1, 1'b0, 4'b0000, 32'h7FFFFFFF, 32'd1,        5'd0};
    vecs[3]  = '{6'h00, 6'b100010, 5'd0, 5'd1, 5'd5, 32'h80000000, 32'd1,        16'h0,    1'b0, 32'h7FFFFFFF, 5'd5,  1'b0, 1'b1, 4'b0001, 32'h80000000, 32'd1,        5'd0};
    vecs[4]  = '{6'h00, 6'b100011, 5'd0, 5'd1, 5'd6, 32'd10,       32'd3,        16'h0,    1'b0, 32'd7,        5'd6,  1'b1, 1'b0, 4'b0001, 32'd10,       32'd3,        5'd0};
    vecs[5]  = '{6'h00, 6'b000011, 5'd4, 5'd2, 5'd7, 32'h12345678, 32'h80000000, 16'h0,    1'b0, 32'hF8000000, 5'd7,  1'b1, 1'b0, 4'b0110, 32'h80000000, 32'h0,        5'd4};
    vecs[6]  = '{6'h00, 6'b000010, 5'd4, 5'd2, 5'd8, 32'h12345678, 32'h80000000, 16'h0,    1'b0, 32'h08000000, 5'd8,  1'b1, 1'b0, 4'b0101, 32'h80000000, 32'h0,        5'd4};
    vecs[7]  = '{6'h00, 6'b000000, 5'd31, 5'd2, 5'd9, 32'hFFFFFFFF, 32'd1,       16'h0,    1'b0, 32'h80000000, 5'd9,  1'b1, 1'b0, 4'b0100, 32'd1,        32'h0,        5'd31};
    vecs[8]  = '{6'h00, 6'b100100, 5'd0, 5'd1, 5'd10, 32'hF0F0F0F0, 32'hFF00FF00, 16'h0,   1'b0, 32'hF000F000, 5'd10, 1'b1, 1'b0, 4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0};
    vecs[9]  = '{6'h00, 6'b100101, 5'd0, 5'd1, 5'd11, 32'hF0F0F0F0, 32'h0F0F0000, 16'h0,   1'b0, 32'hFFFFF0F0, 5'd11, 1'b1, 1'b0, 4'b0011, 32'hF0F0F0F0, 32'h0F0F0000, 5'd0};
    vecs[10] = '{6'h00, 6'b100111, 5'd0, 5'd1, 5'd12, 32'h0,       32'h0,        16'h0,    1'b0, 32'hFFFFFFFF, 5'd12, 1'b1, 1'b0, 4'b1001, 32'h0,        32'h0,        5'd0};
    vecs[11] = '{6'h00, 6'b101010, 5'd0, 5'd1, 5'd13, 32'hFFFFFFFF, 32'd1,       16'h0,    1'b0, 32'd1,        5'd13, 1'b1, 1'b0, 4'b1000, 32'hFFFFFFFF, 32'd1,        5'd0};
    vecs[12] = '{6'b001100, 6'h0, 5'd0, 5'd14, 5'd1, 32'h12345678, 32'h0,       16'hFFFF, 1'b0, 32'h00005678, 5'd14, 1'b1, 1'b0, 4'b0010, 32'h12345678, 32'h0000FFFF, 5'd0};
    vecs[13] = '{6'b001101, 6'h0, 5'd0, 5'd15, 5'd1, 32'h0,        32'h0,        16'h8000, 1'b0, 32'h00008000, 5'd15, 1'b1, 1'b0, 4'b0011, 32'h0,        32'h00008000, 5'd0};
    vecs[14] = '{6'b001000, 6'h0, 5'd0, 5'd16, 5'd1, 32'h7FFFFFFF, 32'h0,        16'h0001, 1'b0, 32'h80000000, 5'd16, 1'b0, 1'b1, 4'b0000, 32'h7FFFFFFF, 32'd1,        5'd0};
    vecs[15] = '{6'b001001, 6'h0, 5'd0, 5'd17, 5'd1, 32'd10,       32'h0,        16'hFFFF, 1'b0, 32'd9,        5'd17, 1'b1, 1'b0, 4'b0000, 32'd10,       32'hFFFFFFFF, 5'd0};
    vecs[16] = '{6'b001010, 6'h0, 5'd0, 5'd18, 5'd1, 32'hFFFFFFFF, 32'h0,        16'h0001, 1'b0, 32'd1,        5'd18, 1'b1, 1'b0, 4'b1000, 32'hFFFFFFFF, 32'd1,        5'd0};
    vecs[17] = '{6'h00, 6'b100001, 5'd0, 5'd1, 5'd0, 32'd1,        32'd2,        16'h0,    1'b0, 32'd3,        5'd0,  1'b0, 1'b0, 4'b0000, 32'd1,        32'd2,        5'd0};
    vecs[18] = '{6'b111111, 6'h0, 5'd0, 5'd19, 5'd1, 32'd1,        32'd2,        16'h0,    1'b1, 32'h0,        5'd19, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        5'd0};
    vecs[19] = '{6'h00, 6'b000001, 5'd0, 5'd1, 5'd20, 32'd1,       32'd2,        16'h0,    1'b1, 32'h0,        5'd20, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        5'd0};
    vecs[20] = '{6'h00, 6'b100000, 5'd0, 5'd1, 5'd21, 32'd1,       32'd2,        16'h0,    1'b0, 32'd3,        5'd21, 1'b1, 1'b0, 4'b0000, 32'd1,        32'd2,        5'd0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(vecs[0]);
    #2;
    chk("reset in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_result", out_result, 32'h0);
    chk("reset alu_data1", alu_data1, 32'h0);
    chk("reset alu_control", {28'd0, alu_control}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      chk($sformatf("v%0d in_ready idle", i), {31'd0, in_ready}, 32'd1);
      accept(vecs[i]);
      if (!vecs[i].ill) begin
        chk($sformatf("v%0d alu_data1", i), alu_data1, vecs[i].d1);
        chk($sformatf("v%0d alu_data2", i), alu_data2, vecs[i].d2);
        chk($sformatf("v%0d alu_control", i), {28'd0, alu_control}, {28'd0, vecs[i].ctl});
        chk($sformatf("v%0d alu_shamt", i), {27'd0, alu_shamt}, {27'd0, vecs[i].ash});
      end
      wait_valid(lat);
      chk($sformatf("v%0d latency", i), lat, vecs[i].ill ? 32'd0 : ALU_LAT + 2);
      chk($sformatf("v%0d out_result", i), out_result, vecs[i].res);
      if (!vecs[i].ill) chk($sformatf("v%0d out_dest", i), {27'd0, out_dest}, {27'd0, vecs[i].dst});
      chk($sformatf("v%0d out_wr_en", i), {31'd0, out_wr_en}, {31'd0, vecs[i].wr});
      chk($sformatf("v%0d out_overflow", i), {31'd0, out_overflow}, {31'd0, vecs[i].ovf});
      chk($sformatf("v%0d out_illegal", i), {31'd0, out_illegal}, {31'd0, vecs[i].ill});
      chk($sformatf("v%0d in_ready busy", i), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk($sformatf("v%0d out_valid drop", i), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: hold out_ready low for 3 cycles in DONE.
    accept(vecs[0]);
    wait_valid(lat);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d out_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d out_result", k), out_result, 32'd12);
      chk($sformatf("stall%0d out_dest", k), {27'd0, out_dest}, 32'd3);
      chk($sformatf("stall%0d in_ready", k), {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("stall release out_valid", {31'd0, out_valid}, 32'd0);
    chk("stall release in_ready", {31'd0, in_ready}, 32'd1);

    // Flush while in EXEC: result discarded, back to IDLE.
    accept(vecs[0]);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush exec in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush exec no out_valid", {31'd0, seen}, 32'd0);

    // Flush beats in_valid in IDLE.
    @(negedge clk);
    drive(vecs[0]);
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush idle in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush idle no accept", {31'd0, seen}, 32'd0);

    // Reset pulse while in WAIT.
    accept(vecs[8]);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("rst wait out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst wait alu_data1", alu_data1, 32'h0);
    chk("rst wait alu_data2", alu_data2, 32'h0);
    chk("rst wait out_result", out_result, 32'h0);
    chk("rst wait in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst wait no out_valid", {31'd0, seen}, 32'd0);
    chk("rst wait in_ready after", {31'd0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
